// File: rtl/tbuf_pkg.sv
// Shared defaults, the data word type and the address-index width helper
// used by the tbuf read/write responder and its read pipeline.
package tbuf_pkg;

    localparam int BUFFD_DEF  = 64;
    localparam int DEPTH_DEF  = 256;
    localparam int RD_LAT_DEF = 2;

    // One data word at the default width.
    typedef logic [BUFFD_DEF*8-1:0] word_t;

    // Bits needed to index a storage of 'depth' words (at least one bit).
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tbuf_rd_pipe.sv
// Fixed-latency read delay line: LAT stages of valid plus data.
// Valids reset asynchronously. The last data stage is also reset, so the
// module output is zero while reset is asserted. Every data stage loads
// only when its incoming valid is high, so the output holds between responses.
module tbuf_rd_pipe #(
    parameter int DW  = 512,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_vld,
    input  logic [DW-1:0] in_data,
    output logic          out_vld,
    output logic [DW-1:0] out_data
);

    genvar g;
    for (g = 0; g < LAT; g++) begin : g_stage
        logic          st_vld;
        logic [DW-1:0] st_data;
        logic          vld_q;
        logic [DW-1:0] data_q;

        if (g == 0) begin : g_head
            assign st_vld  = in_vld;
            assign st_data = in_data;
        end else begin : g_link
            assign st_vld  = g_stage[g-1].vld_q;
            assign st_data = g_stage[g-1].data_q;
        end

        // Valid bit of this stage; an asserted reset flushes reads in flight.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) vld_q <= 1'b0;
            else          vld_q <= st_vld;
        end

        if (g == LAT - 1) begin : g_out
            // Output data register: zero in reset, loads only with a response.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)    data_q <= '0;
                else if (st_vld) data_q <= st_data;
            end
        end else begin : g_mid
            // Inner data register: its contents are qualified by vld_q, so it
            // carries no reset.
            always_ff @(posedge clk) begin
                if (st_vld) data_q <= st_data;
            end
        end
    end

    assign out_vld  = g_stage[LAT-1].vld_q;
    assign out_data = g_stage[LAT-1].data_q;

endmodule

// File: rtl/tbuf_responder.sv
// Single-port-pair word buffer: one write and one read per cycle, no
// backpressure, write-first on address collision, fixed read latency,
// out-of-range accesses dropped (reads return zero) and flagged sticky.
module tbuf_responder
    import tbuf_pkg::*;
#(
    parameter int AW     = 16,
    parameter int BUFFD  = BUFFD_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               init_pulse,
    input  logic [AW-1:0]      raddr,
    input  logic               raddr_vld,
    output logic [BUFFD*8-1:0] rdata,
    output logic               rdata_vld,
    input  logic [AW-1:0]      waddr,
    input  logic [BUFFD*8-1:0] wdata,
    input  logic               wdata_vld,
    output logic [AW-1:0]      rd_cnt,
    output logic [AW-1:0]      wr_cnt,
    output logic               oob_err
);

    localparam int          DW      = BUFFD * 8;
    localparam int          IW      = idx_w(DEPTH);
    localparam logic [AW:0] DEPTH_X = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic          rd_inr;
    logic          wr_inr;
    logic          any_oob;
    logic [IW-1:0] ridx;
    logic [IW-1:0] widx;
    logic [DW-1:0] rd_word;

    // Range checks are one bit wider so DEPTH == 2**AW still compares correctly.
    assign rd_inr  = raddr_vld && ({1'b0, raddr} < DEPTH_X);
    assign wr_inr  = wdata_vld && ({1'b0, waddr} < DEPTH_X);
    assign any_oob = (raddr_vld && !rd_inr) || (wdata_vld && !wr_inr);
    assign ridx    = raddr[IW-1:0];
    assign widx    = waddr[IW-1:0];

    // Storage write; out-of-range writes are dropped.
    // NOTE: the storage array has no reset -- its contents must survive reset_n pulses.
    always_ff @(posedge clk) begin
        if (wr_inr) mem[widx] <= wdata;
    end

    // Read sample in the request cycle: write-first bypass, zero when out of range.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_word = '0;
        if (rd_inr) begin
            if (wr_inr && (widx == ridx)) rd_word = wdata;
            else                          rd_word = mem[ridx];
        end
    end

    tbuf_rd_pipe #(
        .DW  (DW),
        .LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_vld   (raddr_vld),
        .in_data  (rd_word),
        .out_vld  (rdata_vld),
        .out_data (rdata)
    );

    // Access counters and sticky error; init_pulse clears first, then the
    // same-cycle access is applied on top of the cleared value.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            oob_err <= 1'b0;
        end else if (init_pulse) begin
            rd_cnt  <= AW'(rd_inr);
            wr_cnt  <= AW'(wr_inr);
            oob_err <= any_oob;
        end else begin
            if (rd_inr)  rd_cnt  <= rd_cnt + 1'b1;
            if (wr_inr)  wr_cnt  <= wr_cnt + 1'b1;
            if (any_oob) oob_err <= 1'b1;
        end
    end

endmodule

// File: doc/tbuf_responder.md
TBUF_RESPONDER -- requirements
Module: tbuf_responder

Interface
REQ-001 SHALL have parameter AW, default 16, meaning address width of raddr/waddr.
REQ-002 SHALL have parameter BUFFD, default 64, meaning bytes per data word (data width BUFFD*8).
REQ-003 SHALL have parameter DEPTH, default 256, meaning number of stored words (power of two, 2..2**AW).
REQ-004 SHALL have parameter RD_LAT, default 2, meaning read latency in cycles (1..4).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-007 SHALL have port init_pulse, input, 1, which clears counters and the error flag.
REQ-008 SHALL have port raddr, input, AW, giving the read word address.
REQ-009 SHALL have port raddr_vld, input, 1, marking a read request this cycle.
REQ-010 SHALL have port rdata, output, BUFFD*8, carrying the read response data.
REQ-011 SHALL have port rdata_vld, output, 1, marking a read response this cycle.
REQ-012 SHALL have port waddr, input, AW, giving the write word address.
REQ-013 SHALL have port wdata, input, BUFFD*8, carrying the write data.
REQ-014 SHALL have port wdata_vld, input, 1, marking a write this cycle.
REQ-015 SHALL have port rd_cnt, output, AW, counting accepted in-range reads.
REQ-016 SHALL have port wr_cnt, output, AW, counting accepted in-range writes.
REQ-017 SHALL have port oob_err, output, 1, a sticky flag for out-of-range access.

Function
REQ-018 SHALL store DEPTH words of BUFFD*8 bits; no backpressure, one read and one write accepted every cycle.
REQ-019 SHALL, on write with waddr<DEPTH, update word waddr at the clock edge of that cycle.
REQ-020 SHALL, on read with raddr_vld at cycle t, assert rdata_vld with the data exactly at cycle t+RD_LAT, fully pipelined, order preserved.
REQ-021 SHALL, on read and write to the same in-range address in the same cycle, return the new wdata (write-first).
REQ-022 SHALL, for a write at cycle t+k (k>=1) to an address read at cycle t, return the old data (the read samples at cycle t only).
REQ-023 SHALL, on any access with addr>=DEPTH: drop the write; return all-zero data for the read, still with rdata_vld at t+RD_LAT; set oob_err.
REQ-024 SHALL set oob_err on the cycle after the offending access; it stays set until init_pulse or reset.
REQ-025 SHALL increment rd_cnt and wr_cnt by 1 per in-range access, wrapping modulo 2**AW; out-of-range accesses are not counted.
REQ-026 SHALL, when init_pulse and an access occur in the same cycle, clear first and then count the access (counter=1 next cycle); clear first and then set oob_err if that access is out of range.
REQ-027 SHALL NOT let init_pulse affect stored data or in-flight reads.
REQ-028 SHALL hold rdata at its last value while rdata_vld=0.

Reset
REQ-029 SHALL, while reset_n=0, force rdata=0, rdata_vld=0, rd_cnt=0, wr_cnt=0, oob_err=0 and flush the read pipeline asynchronously.
REQ-030 SHALL discard reads in flight when reset asserts; no rdata_vld for them after release.
REQ-031 SHALL NOT reset storage contents; the contents are undefined after power-up and retained across reset_n pulses.
REQ-032 SHALL accept requests from the first rising edge with reset_n=1.

Structure
REQ-033 SHALL place DEPTH/RD_LAT defaults, address-index width function and the data word typedef in shared package tbuf_pkg.
REQ-034 SHALL implement the latency delay line (valid plus data, RD_LAT stages, async-reset valid) as sub-module tbuf_rd_pipe.

Verification
REQ-035 SHALL cover write 0xA5-pattern at addr 3, read addr 3 two cycles later -> rdata=0xA5-pattern, rdata_vld exactly 2 cycles after raddr_vld, rd_cnt=1, wr_cnt=1.
REQ-036 SHALL cover same-cycle write 0x11.. and read at addr 7 (old 0x22..) -> rdata=0x11..; then a read at cycle t with a write 0x33.. at t+1 -> rdata=0x11...
REQ-037 SHALL cover back-to-back reads addr 0..15 on 16 consecutive cycles -> 16 consecutive rdata_vld cycles, data in order.
REQ-038 SHALL cover read addr 256 and write addr 300 (DEPTH=256) -> rdata=0, rdata_vld asserted, word 300%256=44 unchanged, oob_err=1, counters unchanged; then init_pulse -> oob_err=0.
REQ-039 SHALL cover reset_n low for 1 cycle with 2 reads in flight -> no rdata_vld afterwards, outputs 0, previously written addr 3 still reads back 0xA5-pattern.
REQ-040 SHALL cover init_pulse in the same cycle as a write to addr 5 with wr_cnt=9 -> wr_cnt=1 next cycle.
